// File: rtl/iob_gpio_edge.sv
// GPIO block: CPU register port, two-flop pin synchronisers, rise/fall interrupt capture.
// Define IOB_GPIO_DEBOUNCE_EN to build the per-pin debounce filter and the DEB_LIMIT register.
module iob_gpio_edge #(
  parameter int unsigned GPIO_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEB_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [GPIO_W-1:0]   gpio_input,
  output logic [GPIO_W-1:0]   gpio_output,
  output logic [GPIO_W-1:0]   gpio_output_enable,
  output logic                irq
);

  localparam logic [ADDR_W-1:0] A_INPUT      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OUTPUT     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OUT_SET    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_OUT_CLR    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_OUT_EN     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RISE_EN    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_FALL_EN    = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_IRQ_STATUS = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_IRQ_MASK   = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_DEB_LIMIT  = ADDR_W'(9);

  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] bmask;
  logic [GPIO_W-1:0] gmask;
  logic [GPIO_W-1:0] wbits;

  logic [GPIO_W-1:0] out_q, oen_q, ren_q, fen_q, sts_q, msk_q;
  logic [GPIO_W-1:0] out_nxt, oen_nxt, ren_nxt, fen_nxt, sts_nxt, msk_nxt;
  logic [GPIO_W-1:0] sync_1, sync_in, filt_in, filt_d;
  logic [GPIO_W-1:0] rise, fall;
  logic [DATA_W-1:0] rd_mux;

  assign wr = valid && (wstrb != '0);
  assign rd = valid && (wstrb == '0);

  // Expand byte strobes to a per-bit write mask
  for (genvar j = 0; j < DATA_W; j++) begin : g_bmask
    assign bmask[j] = wstrb[j/8];
  end

  assign gmask = bmask[GPIO_W-1:0];
  assign wbits = wdata[GPIO_W-1:0] & gmask;

  assign gpio_output        = out_q;
  assign gpio_output_enable = oen_q;

  // Register writes and sticky edge capture; a new edge beats a same-cycle W1C
  always_comb begin
    out_nxt = out_q;
    oen_nxt = oen_q;
    ren_nxt = ren_q;
    fen_nxt = fen_q;
    sts_nxt = sts_q;
    msk_nxt = msk_q;
    rise    = filt_in & ~filt_d;
    fall    = ~filt_in & filt_d;
    if (wr) begin
      case (address)
        A_OUTPUT:     out_nxt = (out_q & ~gmask) | wbits;
        A_OUT_SET:    out_nxt = out_q | wbits;
        A_OUT_CLR:    out_nxt = out_q & ~wbits;
        A_OUT_EN:     oen_nxt = (oen_q & ~gmask) | wbits;
        A_RISE_EN:    ren_nxt = (ren_q & ~gmask) | wbits;
        A_FALL_EN:    fen_nxt = (fen_q & ~gmask) | wbits;
        A_IRQ_STATUS: sts_nxt = sts_q & ~wbits;
        A_IRQ_MASK:   msk_nxt = (msk_q & ~gmask) | wbits;
        default:      ;
      endcase
    end
    sts_nxt = sts_nxt | (rise & ren_q) | (fall & fen_q);
  end

`ifdef IOB_GPIO_DEBOUNCE_EN
  logic [DEB_W-1:0] deb_limit;
  logic [DEB_W-1:0] deb_nxt;
  logic [DEB_W-1:0] deb_cnt [GPIO_W];

  always_comb begin
    deb_nxt = deb_limit;
    if (wr && (address == A_DEB_LIMIT)) begin
      deb_nxt = (deb_limit & ~bmask[DEB_W-1:0]) | (wdata[DEB_W-1:0] & bmask[DEB_W-1:0]);
    end
  end

  // A pin's filtered level follows only after it disagrees for DEB_LIMIT+1 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_limit <= '0;
      filt_in   <= '0;
      for (int i = 0; i < GPIO_W; i++) deb_cnt[i] <= '0;
    end else begin
      deb_limit <= deb_nxt;
      for (int i = 0; i < GPIO_W; i++) begin
        if (sync_in[i] == filt_in[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == deb_limit) begin
          filt_in[i] <= sync_in[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_in <= '0;
    else     filt_in <= sync_in;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      A_INPUT:      rd_mux = DATA_W'(filt_in);
      A_OUTPUT:     rd_mux = DATA_W'(out_q);
      A_OUT_EN:     rd_mux = DATA_W'(oen_q);
      A_RISE_EN:    rd_mux = DATA_W'(ren_q);
      A_FALL_EN:    rd_mux = DATA_W'(fen_q);
      A_IRQ_STATUS: rd_mux = DATA_W'(sts_q);
      A_IRQ_MASK:   rd_mux = DATA_W'(msk_q);
`ifdef IOB_GPIO_DEBOUNCE_EN
      A_DEB_LIMIT:  rd_mux = DATA_W'(deb_limit);
`else
      A_DEB_LIMIT:  rd_mux = DATA_W'({DEB_W{1'b0}});
`endif
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      oen_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      sts_q   <= '0;
      msk_q   <= '0;
      sync_1  <= '0;
      sync_in <= '0;
      filt_d  <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      irq     <= 1'b0;
    end else begin
      out_q   <= out_nxt;
      oen_q   <= oen_nxt;
      ren_q   <= ren_nxt;
      fen_q   <= fen_nxt;
      sts_q   <= sts_nxt;
      msk_q   <= msk_nxt;
      sync_1  <= gpio_input;
      sync_in <= sync_1;
      filt_d  <= filt_in;
      ready   <= valid;
      rdata   <= rd ? rd_mux : '0;
      irq     <= |(sts_nxt & msk_nxt);
    end
  end

endmodule

// File: tb/tb_iob_gpio_edge.sv
// Scoreboard bench for iob_gpio_edge: randomized register traffic and pin changes
// checked against a settled-level register model; directed edge, W1C, debounce and reset cases.
module tb_iob_gpio_edge;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] gpio_input;
  logic [31:0] gpio_output;
  logic [31:0] gpio_output_enable;
  logic        irq;

  always #5 clk = ~clk;

  iob_gpio_edge dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .gpio_input(gpio_input), .gpio_output(gpio_output),
    .gpio_output_enable(gpio_output_enable), .irq(irq)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  // Register model: pin levels are tracked only once they have settled
  logic [31:0] m_out, m_oen, m_ren, m_fen, m_sts, m_msk, m_pins;
  logic [7:0]  m_deb;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  function automatic void m_reset();
    m_out = '0; m_oen = '0; m_ren = '0; m_fen = '0;
    m_sts = '0; m_msk = '0; m_pins = '0; m_deb = '0;
  endfunction

  function automatic logic [31:0] bm(input logic [3:0] ws);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (ws[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return m_pins;
      4'd1:    return m_out;
      4'd4:    return m_oen;
      4'd5:    return m_ren;
      4'd6:    return m_fen;
      4'd7:    return m_sts;
      4'd8:    return m_msk;
      4'd9:    return {24'h0, m_deb};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] m;
    logic [31:0] v;
    m = bm(ws);
    v = wd & m;
    case (a)
      4'd1: m_out = (m_out & ~m) | v;
      4'd2: m_out = m_out | v;
      4'd3: m_out = m_out & ~v;
      4'd4: m_oen = (m_oen & ~m) | v;
      4'd5: m_ren = (m_ren & ~m) | v;
      4'd6: m_fen = (m_fen & ~m) | v;
      4'd7: m_sts = m_sts & ~v;
      4'd8: m_msk = (m_msk & ~m) | v;
      4'd9: begin
`ifdef IOB_GPIO_DEBOUNCE_EN
        m_deb = (m_deb & ~m[7:0]) | v[7:0];
`endif
      end
      default: ;
    endcase
  endfunction

  function automatic void m_pins_update(input logic [31:0] nv);
    m_sts  = m_sts | ((nv & ~m_pins) & m_ren) | ((~nv & m_pins) & m_fen);
    m_pins = nv;
  endfunction

  // Issue one request at a negedge; caller calls idle() to end a burst
  task automatic req(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    e.cyc   = cyc;
    e.is_rd = (ws == 4'h0);
    e.exp   = e.is_rd ? m_read(a) : 32'h0;
    sbq.push_back(e);
    if (!e.is_rd) m_write(a, wd, ws);
    valid = 1'b1; address = a; wdata = wd; wstrb = ws;
    @(negedge clk);
  endtask

  task automatic idle();
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic settle();
    int unsigned n;
    n = 6;
`ifdef IOB_GPIO_DEBOUNCE_EN
    n = n + 32'(m_deb);
`endif
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs();
    check("gpio_output", gpio_output, m_out);
    check("gpio_output_enable", gpio_output_enable, m_oen);
    check("irq", 32'(irq), 32'(|(m_sts & m_msk)));
  endtask

  task automatic set_pins(input logic [31:0] nv);
    gpio_input = nv;
    m_pins_update(nv);
    settle();
    check_outs();
  endtask

  // Monitor: every ready must match the oldest outstanding request, one cycle after it
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: got ready=1 at cycle %0d required no ready", cyc);
      end else begin
        e = sbq.pop_front();
        check("ready_latency", 32'(cyc), 32'(e.cyc + 1));
        if (e.is_rd) check("rdata", rdata, e.exp);
      end
    end else if (sbq.size() != 0 && sbq[0].cyc + 1 <= cyc) begin
      e = sbq.pop_front();
      check("missing_ready", 32'(0), 32'(1));
    end
  end

  initial begin
    int n;
    rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0; gpio_input = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check_outs();
    rst = 1'b0;

    // Reset values of the whole map, back-to-back
    for (int a = 0; a < 16; a++) req(4'(a), 32'h0, 4'h0);
    idle();
    settle();
    check_outs();

    // Output write, clear and set
    req(4'd1, 32'hFF, 4'hF);
    req(4'd3, 32'h0F, 4'hF);
    req(4'd2, 32'h100, 4'hF);
    req(4'd1, 32'h0, 4'h0);
    req(4'd2, 32'h0, 4'h0);
    req(4'd3, 32'h0, 4'h0);
    idle();
    check("out_set_clr", gpio_output, 32'h1F0);
    check_outs();

    // Enabled rise raises irq within 5 cycles; W1C lowers it next cycle
    req(4'd5, 32'h1, 4'hF);
    req(4'd8, 32'h1, 4'hF);
    idle();
    gpio_input = 32'h1;
    m_pins_update(32'h1);
    n = 0;
    while (irq !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("irq_rise_latency", 32'(irq), 32'h1);
    settle();
    req(4'd7, 32'h0, 4'h0);
    req(4'd7, 32'h1, 4'hF);
    idle();
    check("irq_after_w1c", 32'(irq), 32'h0);

    // Fall capture with mask off, then unmask
    req(4'd6, 32'h2, 4'hF);
    idle();
    set_pins(32'h3);
    set_pins(32'h1);
    req(4'd7, 32'h0, 4'h0);
    req(4'd8, 32'h2, 4'hF);
    idle();
    check_outs();

    // W1C in the very cycle a new enabled rise sets the bit
    set_pins(32'h0);
    req(4'd7, 32'hFFFF_FFFF, 4'hF);
    idle();
    gpio_input = 32'h1;
    repeat (3) @(negedge clk);
    req(4'd7, 32'h1, 4'hF);
    m_pins_update(32'h1);
    idle();
    settle();
    req(4'd7, 32'h0, 4'h0);
    idle();

`ifdef IOB_GPIO_DEBOUNCE_EN
    // Short glitch is filtered, long pulse passes as a single rise
    set_pins(32'h0);
    req(4'd9, 32'd10, 4'hF);
    idle();
    gpio_input = 32'h1;
    repeat (5) @(negedge clk);
    gpio_input = 32'h0;
    settle();
    req(4'd0, 32'h0, 4'h0);
    req(4'd7, 32'h0, 4'h0);
    idle();
    set_pins(32'h1);
    repeat (4) @(negedge clk);
    req(4'd0, 32'h0, 4'h0);
    req(4'd7, 32'h0, 4'h0);
    req(4'd9, 32'h0, 4'h1);
    idle();
`else
    req(4'd9, 32'hAB, 4'hF);
    req(4'd9, 32'h0, 4'h0);
    idle();
`endif

    // Randomized traffic and pin changes
    for (int k = 0; k < 250; k++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5) begin
        req(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(1, 15)));
        idle();
        check_outs();
      end else if (op < 7) begin
        req(4'($urandom_range(0, 15)), 32'h0, 4'h0);
        idle();
      end else if (op < 9) begin
        set_pins(gpio_input ^ $urandom);
      end else begin
        for (int b = 0; b < 4; b++)
          req(4'($urandom_range(0, 15)), $urandom, (b == 2) ? 4'h0 : 4'($urandom_range(0, 15)));
        idle();
        check_outs();
      end
    end

    // Reset during a read with pins high: outputs drop at once, the read is dropped
    req(4'd5, 32'hFFFF_FFFF, 4'hF);
    req(4'd8, 32'hFFFF_FFFF, 4'hF);
    req(4'd4, 32'h00FF, 4'hF);
    req(4'd1, 32'h1F0, 4'hF);
    idle();
    set_pins(32'h0);
    set_pins(32'h0000_A5A5);
    valid = 1'b1; address = 4'd1; wstrb = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    valid = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_gpio_output", gpio_output, 32'h0);
    check("rst_gpio_oe", gpio_output_enable, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req(4'd5, 32'hFFFF_FFFF, 4'hF);
    idle();
    m_pins_update(gpio_input);
    settle();
    req(4'd7, 32'h0, 4'h0);
    req(4'd0, 32'h0, 4'h0);
    idle();
    check_outs();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_gpio_edge.md
IOB_GPIO_EDGE -- requirements
Module: iob_gpio_edge

Interface
REQ-001 SHALL have parameter GPIO_W, default 32, number of GPIO pins (1..DATA_W).
REQ-002 SHALL have parameter DATA_W, default 32, CPU data width.
REQ-003 SHALL have parameter ADDR_W, default 4, CPU word-address width.
REQ-004 SHALL have parameter DEB_W, default 8, debounce counter and limit width.
REQ-005 SHALL have ports: clk in 1, system clock; rst in 1, reset, asynchronous and active-high.
REQ-006 SHALL have ports: valid in 1, CPU request; address in ADDR_W, word address; wdata in DATA_W, write data; wstrb in DATA_W/8, byte write strobes (all zero means read).
REQ-007 SHALL have ports: rdata out DATA_W, read data; ready out 1, request accepted.
REQ-008 SHALL have ports: gpio_input in GPIO_W, pins; gpio_output out GPIO_W, output levels; gpio_output_enable out GPIO_W, tristate enables; irq out 1, interrupt.

Function
REQ-009 SHALL decode the word-address map: 0 INPUT RO; 1 OUTPUT RW; 2 OUT_SET WO; 3 OUT_CLR WO; 4 OUT_EN RW; 5 RISE_EN RW; 6 FALL_EN RW; 7 IRQ_STATUS W1C; 8 IRQ_MASK RW; 9 DEB_LIMIT RW (DEB_W bits); other addresses read 0 and ignore writes.
REQ-010 SHALL assert ready exactly one cycle after each cycle with valid high, with rdata valid in that ready cycle; back-to-back requests SHALL be served every cycle.
REQ-011 SHALL apply writes byte-wise per wstrb; bits above GPIO_W SHALL read 0.
REQ-012 SHALL make OUT_SET write OUTPUT |= wdata and OUT_CLR write OUTPUT &= ~wdata in one cycle; reads of 2 and 3 return 0.
REQ-013 SHALL pass gpio_input through a two-flop synchroniser per pin; the synchronised value is sync_in.
REQ-014 SHALL derive filt_in from sync_in (see Configuration); INPUT SHALL read filt_in.
REQ-015 SHALL keep a one-cycle delayed copy filt_d; rise = filt_in & ~filt_d, fall = ~filt_in & filt_d.
REQ-016 SHALL set IRQ_STATUS[i] on the cycle after rise[i]&RISE_EN[i] or fall[i]&FALL_EN[i]; bits are sticky.
REQ-017 SHALL clear IRQ_STATUS bits written with 1; on simultaneous set and clear of the same bit, set SHALL win.
REQ-018 SHALL drive irq = |(IRQ_STATUS & IRQ_MASK) from registers, no combinational path from pins.
REQ-019 SHALL not generate edges for enables changed while an edge is present; only the enable value in the edge cycle counts.

Reset
REQ-020 SHALL, on rst high, asynchronously clear OUTPUT, OUT_EN, RISE_EN, FALL_EN, IRQ_STATUS, IRQ_MASK, synchronisers, filt_in, filt_d, debounce counters, ready, rdata, irq.
REQ-021 SHALL reset DEB_LIMIT to 0.
REQ-022 SHALL drop any in-flight request on reset; no ready SHALL follow it.
REQ-023 SHALL suppress edges in the first cycle after reset release, since filt_in and filt_d are both 0 until inputs propagate; a pin held high through reset SHALL produce a rise.

Configuration
REQ-024 SHALL compile a per-pin debounce filter when IOB_GPIO_DEBOUNCE_EN is defined.
REQ-025 With IOB_GPIO_DEBOUNCE_EN: per pin a DEB_W counter; when sync_in[i]==filt_in[i] counter clears; otherwise it increments and, when it equals DEB_LIMIT, filt_in[i] takes sync_in[i] and counter clears. DEB_LIMIT=0 SHALL update filt_in the cycle after sync_in changes.
REQ-026 Without IOB_GPIO_DEBOUNCE_EN: filt_in = sync_in registered once (same latency as DEB_LIMIT=0); DEB_LIMIT SHALL read 0 and ignore writes.

Verification
REQ-027 Write 0xFF to OUTPUT, 0x0F to OUT_CLR, 0x100 to OUT_SET -> gpio_output 0x1F0; reads of OUTPUT return 0x1F0, each ready one cycle after valid.
REQ-028 RISE_EN=0x1, IRQ_MASK=0x1, gpio_input[0] 0->1 -> IRQ_STATUS=0x1 and irq high within 5 cycles; W1C 0x1 -> irq low the next cycle.
REQ-029 FALL_EN=0x2, mask 0: pin1 1->0 -> IRQ_STATUS=0x2, irq stays 0; then IRQ_MASK=0x2 -> irq 1.
REQ-030 W1C to bit0 in the same cycle a new enabled rise on pin0 sets it -> IRQ_STATUS[0] remains 1.
REQ-031 IOB_GPIO_DEBOUNCE_EN, DEB_LIMIT=10: pin0 glitch high 5 cycles -> INPUT[0] stays 0, no status; held high 20 cycles -> INPUT[0]=1, one rise.
REQ-032 Assert rst mid-read with pins high -> all outputs 0 immediately, no ready; after release, enabled rise recorded for each high pin.
